// File: rtl/dma_pkg.sv
// ============================================================================
// Module : dma_pkg
// Brief  : Shared types and constants for the DMA transfer engine and register block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

    localparam int CTRL_START    = 0;
    localparam int CTRL_DIR      = 1;
    localparam int CTRL_IO_FIXED = 2;
    localparam int CTRL_ABORT    = 3;
    localparam int CTRL_LEN_LSB  = 16;

    localparam logic [11:0] REG_CONTROL     = 12'h400;
    localparam logic [11:0] REG_IO_ADDRESS  = 12'h404;
    localparam logic [11:0] REG_MEM_ADDRESS = 12'h408;
    localparam logic [11:0] REG_INTR        = 12'h40C;

endpackage

`default_nettype wire

// File: rtl/dma_addr_gen.sv
// ============================================================================
// Module : dma_addr_gen
// Brief  : Source/destination address registers with load, stride advance and IO hold.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int STRIDE_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  dir_i,
    input  logic                  io_fixed_i,
    input  logic [ADDR_WIDTH-1:0] io_addr_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic                  adv_i,
    output logic [ADDR_WIDTH-1:0] src_o,
    output logic [ADDR_WIDTH-1:0] dst_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRIDE_BYTES);

    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic                  hold_src_q;
    logic                  hold_dst_q;

    // The IO side is the source for io->mem and the destination for mem->io.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= '0;
            dst_q      <= '0;
            hold_src_q <= 1'b0;
            hold_dst_q <= 1'b0;
        end else if (load_i) begin
            src_q      <= dir_i ? mem_addr_i : io_addr_i;
            dst_q      <= dir_i ? io_addr_i : mem_addr_i;
            hold_src_q <= io_fixed_i & ~dir_i;
            hold_dst_q <= io_fixed_i & dir_i;
        end else if (adv_i) begin
            if (!hold_src_q) src_q <= src_q + STEP;
            if (!hold_dst_q) dst_q <= dst_q + STEP;
        end
    end

    assign src_o = src_q;
    assign dst_o = dst_q;

endmodule

`default_nettype wire

// File: rtl/dma_xfer_engine.sv
// ============================================================================
// Module : dma_xfer_engine
// Brief  : Register-driven word mover: read-then-write per word over one valid/ready port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dma_xfer_engine
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] control,
    input  logic [DATA_WIDTH-1:0] io_address,
    input  logic [DATA_WIDTH-1:0] mem_address,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_wr_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  busy,
    output logic                  intr_done,
    output logic                  intr_err,
    output logic [LEN_WIDTH-1:0]  words_left
);

    dma_state_e            state_q, state_d;
    logic                  start_q;
    logic                  armed_q;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  abort_q, abort_d;
    logic                  busy_q, busy_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_wr_en_q, m_wr_en_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic                  intr_done_q, intr_done_d;
    logic                  intr_err_q, intr_err_d;

    logic                  ag_load;
    logic                  ag_adv;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [LEN_WIDTH-1:0]  len_field;
    logic                  start_pulse;
    logic                  abort_req;
    logic                  unused_bits;

    assign len_field   = control[CTRL_LEN_LSB +: LEN_WIDTH];
    // armed_q blocks a START level still high across reset from counting as an edge.
    assign start_pulse = control[CTRL_START] & ~start_q & armed_q & (state_q == ST_IDLE);
    assign abort_req   = control[CTRL_ABORT] | abort_q;
    assign unused_bits = ^{control, io_address, mem_address};

    dma_addr_gen #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .STRIDE_BYTES (DATA_WIDTH / 8)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (ag_load),
        .dir_i      (control[CTRL_DIR]),
        .io_fixed_i (control[CTRL_IO_FIXED]),
        .io_addr_i  (io_address[ADDR_WIDTH-1:0]),
        .mem_addr_i (mem_address[ADDR_WIDTH-1:0]),
        .adv_i      (ag_adv),
        .src_o      (src_addr),
        .dst_o      (dst_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            buf_q       <= '0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            m_wr_en_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            intr_done_q <= 1'b0;
            intr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= control[CTRL_START];
            armed_q     <= armed_q | ~control[CTRL_START];
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            m_valid_q   <= m_valid_d;
            m_wr_en_q   <= m_wr_en_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            intr_done_q <= intr_done_d;
            intr_err_q  <= intr_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        abort_d     = abort_q;
        busy_d      = busy_q;
        m_valid_d   = m_valid_q;
        m_wr_en_d   = m_wr_en_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        intr_done_d = 1'b0;
        intr_err_d  = 1'b0;
        ag_load     = 1'b0;
        ag_adv      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    ag_load = 1'b1;
                    cnt_d   = len_field;
                    abort_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (len_field == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                if (control[CTRL_ABORT]) abort_d = 1'b1;
                if (!m_valid_q) begin
                    if (abort_req) begin
                        state_d = ST_DONE;
                    end else begin
                        m_valid_d = 1'b1;
                        m_wr_en_d = 1'b0;
                        m_addr_d  = src_addr;
                    end
                end else if (m_ready) begin
                    buf_d     = m_rdata;
                    m_valid_d = 1'b0;
                    state_d   = abort_req ? ST_DONE : ST_WR;
                end
            end
            ST_WR: begin
                if (control[CTRL_ABORT]) abort_d = 1'b1;
                if (!m_valid_q) begin
                    if (abort_req) begin
                        state_d = ST_DONE;
                    end else begin
                        m_valid_d = 1'b1;
                        m_wr_en_d = 1'b1;
                        m_addr_d  = dst_addr;
                        m_wdata_d = buf_q;
                    end
                end else if (m_ready) begin
                    cnt_d     = cnt_q - LEN_WIDTH'(1);
                    ag_adv    = 1'b1;
                    m_valid_d = 1'b0;
                    state_d   = (abort_req || cnt_q == LEN_WIDTH'(1)) ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: begin
                intr_done_d = 1'b1;
                intr_err_d  = abort_q;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_addr     = m_addr_q;
    assign m_wr_en    = m_wr_en_q;
    assign m_valid    = m_valid_q;
    assign m_wdata    = m_wdata_q;
    assign busy       = busy_q;
    assign intr_done  = intr_done_q;
    assign intr_err   = intr_err_q;
    assign words_left = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_xfer_engine.sv
// ============================================================================
// Module : tb_dma_xfer_engine
// Brief  : Directed bench for dma_xfer_engine with a transaction-list reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dma_xfer_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] control = '0;
    logic [31:0] io_address = '0;
    logic [31:0] mem_address = '0;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_addr;
    logic        m_wr_en;
    logic        m_valid;
    logic [31:0] m_wdata;
    logic        busy;
    logic        intr_done;
    logic        intr_err;
    logic [15:0] words_left;

    dma_xfer_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .control     (control),
        .io_address  (io_address),
        .mem_address (mem_address),
        .m_addr      (m_addr),
        .m_wr_en     (m_wr_en),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .busy        (busy),
        .intr_done   (intr_done),
        .intr_err    (intr_err),
        .words_left  (words_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    int          vectors = 0;
    int          miscompares = 0;
    op_t         exp_q[$];
    int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [15:0] exp_words = '0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0;
    int          max_stall = 0;
    int          stall_wr_idx = -1;

    function automatic logic [31:0] rdata_of(input int k, input logic [31:0] a);
        return 32'hA500_0000 + (32'(k) << 16) + {16'h0, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference transfer: word k reads src_k and writes the same data to dst_k.
    task automatic plan(input bit dir, input bit fixed, input int nwords,
                        input logic [31:0] io, input logic [31:0] mem);
        logic [31:0] s, d;
        for (int k = 0; k < nwords; k++) begin
            s = (dir ? mem : io) + ((!dir && fixed) ? 32'd0 : 32'(4 * k));
            d = (dir ? io : mem) + (( dir && fixed) ? 32'd0 : 32'(4 * k));
            exp_q.push_back('{wr: 1'b0, addr: s, data: 32'h0});
            exp_q.push_back('{wr: 1'b1, addr: d, data: rdata_of(k, s)});
        end
    endtask

    // Memory/IO responder with programmable stall per request.
    bit req_active = 1'b0;
    int stall_left = 0;
    always @(posedge clk) begin
        #1;
        if (!reset || !m_valid) begin
            m_ready    = 1'b0;
            req_active = 1'b0;
        end else begin
            if (!req_active) begin
                req_active = 1'b1;
                if (m_wr_en && wr_cnt == stall_wr_idx) stall_left = 4;
                else stall_left = int'($urandom_range(32'(max_stall)));
            end
            if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = 1'b1;
            end
            m_rdata = rdata_of(rd_cnt, m_addr);
        end
    end

    // Compare process: protocol rules plus the expected transaction list.
    logic        pv = 1'b0, pr = 1'b0, pwr = 1'b0;
    logic [31:0] pa = '0, pd = '0;
    always @(negedge clk) begin
        if (!reset) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_valid", m_valid, 1);
                check("hold_addr", m_addr, pa);
                check("hold_wr_en", m_wr_en, pwr);
                if (pwr) check("hold_wdata", m_wdata, pd);
            end
            if (pv && pr) check("gap_after_accept", m_valid, 0);
            check("err_without_done", intr_err & ~intr_done, 0);
            if (busy) check("words_left", words_left, exp_words);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_request");
                end else begin
                    op_t e;
                    e = exp_q.pop_front();
                    check("req_wr_en", m_wr_en, e.wr);
                    check("req_addr", m_addr, e.addr);
                    if (e.wr) check("req_wdata", m_wdata, e.data);
                end
                if (!m_wr_en) begin
                    rd_cnt++;
                    last_rd_addr = m_addr;
                end else begin
                    wr_cnt++;
                    last_wr_addr = m_addr;
                    exp_words = exp_words - 16'd1;
                end
            end
            if (intr_done) done_cnt++;
            if (intr_err) err_cnt++;
            pv = m_valid; pr = m_ready; pwr = m_wr_en; pa = m_addr; pd = m_wdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0;
        exp_q.delete();
    endtask

    task automatic start_xfer(input bit dir, input bit fixed, input logic [15:0] len,
                              input logic [31:0] io, input logic [31:0] mem);
        io_address  = io;
        mem_address = mem;
        exp_words   = len;
        control     = {len, 12'h0, 1'b0, fixed, dir, 1'b1};
        tick(1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (done_cnt > d0) break;
        end
        if (done_cnt == d0) fail_now({name, "_timeout"});
    endtask

    task automatic end_checks(input string name, input int e_err, input logic [15:0] e_wl,
                              input int e_rd, input int e_wr);
        tick(3);
        check({name, "_done_pulses"}, 32'(done_cnt), 1);
        check({name, "_err_pulses"}, 32'(err_cnt), 32'(e_err));
        check({name, "_words_left"}, {16'h0, words_left}, {16'h0, e_wl});
        check({name, "_busy_idle"}, busy, 0);
        check({name, "_reads"}, 32'(rd_cnt), 32'(e_rd));
        check({name, "_writes"}, 32'(wr_cnt), 32'(e_wr));
        check({name, "_pending"}, 32'(exp_q.size()), 0);
        control = '0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_intr_done", intr_done, 0);
        check("rst_intr_err", intr_err, 0);
        check("rst_words_left", {16'h0, words_left}, 0);
        check("rst_m_addr", m_addr, 0);
        reset = 1'b1;
        tick(2);

        // 1: io->mem, registers changed after start must not matter
        begin_test();
        plan(0, 0, 4, 32'h1000, 32'h2000);
        start_xfer(0, 0, 16'd4, 32'h1000, 32'h2000);
        io_address      = 32'hDEAD_0000;
        mem_address     = 32'hBEEF_0000;
        control[31:16]  = 16'd9;
        wait_done("t1", 200);
        check("t1_last_rd", last_rd_addr, 32'h100C);
        check("t1_last_wr", last_wr_addr, 32'h200C);
        end_checks("t1", 0, 16'd0, 4, 4);

        // 2: mem->io with fixed IO address
        begin_test();
        plan(1, 1, 3, 32'h500, 32'h3000);
        start_xfer(1, 1, 16'd3, 32'h500, 32'h3000);
        wait_done("t2", 200);
        check("t2_last_rd", last_rd_addr, 32'h3008);
        check("t2_last_wr", last_wr_addr, 32'h500);
        end_checks("t2", 0, 16'd0, 3, 3);

        // 3: zero-length start
        begin_test();
        control = 32'h0000_0001;
        @(negedge clk);
        check("t3_busy_pre", busy, 0);
        @(negedge clk);
        check("t3_busy_c1", busy, 1);
        check("t3_done_c1", intr_done, 0);
        @(negedge clk);
        check("t3_busy_c2", busy, 0);
        check("t3_done_c2", intr_done, 1);
        check("t3_err_c2", intr_err, 0);
        @(negedge clk);
        check("t3_done_c3", intr_done, 0);
        tick(1);
        end_checks("t3", 0, 16'd0, 0, 0);

        // 4: random backpressure, memory address wrapping through zero
        begin_test();
        max_stall = 5;
        plan(0, 0, 8, 32'h4000, 32'hFFFF_FFF0);
        start_xfer(0, 0, 16'd8, 32'h4000, 32'hFFFF_FFF0);
        wait_done("t4", 2000);
        check("t4_last_wr_wrapped", last_wr_addr, 32'h0000_000C);
        end_checks("t4", 0, 16'd0, 8, 8);
        max_stall = 0;

        // 5: abort during stalled third write
        begin_test();
        stall_wr_idx = 2;
        plan(0, 0, 3, 32'h6000, 32'h7000);
        start_xfer(0, 0, 16'd6, 32'h6000, 32'h7000);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk);
                #2;
                if (m_valid && m_wr_en && wr_cnt == 2) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) fail_now("t5_third_write_timeout");
        end
        control[3] = 1'b1;
        tick(1);
        control[3] = 1'b0;
        wait_done("t5", 200);
        stall_wr_idx = -1;
        end_checks("t5", 1, 16'd3, 3, 3);

        // abort in idle is ignored
        control = 32'h0000_0008;
        tick(4);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", 32'(done_cnt), 1);
        control = '0;
        tick(1);

        // 6: reset during the second read, then START level held across reset
        begin_test();
        plan(0, 0, 4, 32'h9000, 32'hA000);
        start_xfer(0, 0, 16'd4, 32'h9000, 32'hA000);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk);
                #2;
                if (m_valid && !m_wr_en && rd_cnt == 1) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) fail_now("t6_second_read_timeout");
        end
        #1;
        reset = 1'b0;
        #1;
        check("t6_async_valid", m_valid, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_done", intr_done, 0);
        check("t6_async_err", intr_err, 0);
        exp_q.delete();
        done_cnt = 0;
        tick(2);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("t6_held_start_busy", busy, 0);
            check("t6_held_start_valid", m_valid, 0);
        end
        check("t6_no_intr", 32'(done_cnt), 0);
        control = '0;
        tick(1);
        begin_test();
        plan(0, 0, 2, 32'hB000, 32'hC000);
        start_xfer(0, 0, 16'd2, 32'hB000, 32'hC000);
        wait_done("t6b", 200);
        end_checks("t6b", 0, 16'd0, 2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
